// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS core front end.
//               NOP_INST         - all-zero word (sll $0,$0,0), used to flush
//                                  the IF/ID register
//               DEFAULT_RESET_PC - reset fetch address
//               fetch_state_t    - fetch sequencer states
//               word_align()     - clears the byte-offset bits of an address
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  // Instruction addresses are always word aligned; bits [1:0] are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_skid_reg
// Description : One-entry data+valid holding register. Catches an instruction
//               word returned while decode is stalled.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   load_i   in   capture data_i, mark entry valid
//   clear_i  in   drop the entry (highest priority)
//   pop_i    in   entry consumed, mark invalid
//   data_i   in   word to capture
//   valid_o  out  entry holds a live word
//   data_o   out  captured word
// Revision    : 1.0 - initial release
// ============================================================================
module if_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : if_skid_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction fetch stage plus IF/ID pipeline register.
//               Holds the PC, keeps at most one instruction-memory read in
//               flight, buffers the returned word for decode, honours decode
//               stall and branch/jump redirect.
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   imem_req     out  read request valid
//   imem_addr    out  read address (current PC)
//   imem_gnt     in   address accepted this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   instruction word
//   stall        in   decode cannot accept a new instruction
//   redirect     in   branch/jump taken: flush and refetch
//   redirect_pc  in   new PC (bits [1:0] ignored)
//   id_valid     out  IF/ID holds a live instruction
//   id_inst      out  IF/ID instruction
//   id_pc_plus4  out  fetch PC + 4 of that instruction
//   id_imm       out  id_inst[15:0] for the immediate extender
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_inst,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [15:0]       id_imm
);

  localparam logic [ADDR_W-1:0] C_PC_INC = ADDR_W'(4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;

  logic              skid_load, skid_pop, skid_clear;
  logic              skid_valid;
  logic [31:0]       skid_data;
  logic              w_accept;
  logic [ADDR_W-1:0] w_pc_inc;

  // IF/ID can take a word when decode is not stalled or the register is empty.
  assign w_accept = !stall || !id_valid_q;
  // Wraps modulo 2^ADDR_W.
  assign w_pc_inc = pc_q + C_PC_INC;

  if_skid_reg #(.W(32)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pop_i   (skid_pop),
    .data_i  (imem_rdata),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc4_d   = id_pc4_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    // Without a load this cycle an unstalled IF/ID drains to a bubble;
    // a stalled one keeps everything.
    if (!stall) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          pc_d = w_pc_inc;
          if (w_accept) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc4_d   = w_pc_inc;
            state_d    = REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        // pc already advanced when the word was captured, so pc_q is the
        // skid word's PC + 4.
        if (!stall && skid_valid) begin
          id_valid_d = 1'b1;
          id_inst_d  = skid_data;
          id_pc4_d   = pc_q;
          skid_pop   = 1'b1;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides every load and stall decision above.
    if (redirect) begin
      pc_d       = word_align(redirect_pc);
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      id_pc4_d   = id_pc4_q;
      skid_load  = 1'b0;
      skid_pop   = 1'b0;
      skid_clear = 1'b1;
      case (state_q)
        REQ:     state_d = imem_gnt ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        HOLD:    state_d = REQ;
        IDLE:    state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= (state_d == REQ);
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc_plus4 = id_pc4_q;
  assign id_imm      = id_inst_q[15:0];

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed bench for if_fetch_stage with a memory responder and
//               an in-order instruction-stream model of what decode must see.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic [15:0] id_imm;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc_plus4 (id_pc_plus4),
    .id_imm      (id_imm)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents: distinct word per address, imm field 0x0005 for low addresses.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 + (a << 14);
  endfunction

  // ---------------- model state ----------------
  typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  int          epoch = 0;
  bit          pend = 1'b0;
  int          pend_due, pend_epoch;
  logic [31:0] pend_addr;
  int          cyc = 0;
  int          lat = 1;
  bit          mon_en = 1'b0;

  // Memory response driver.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend && cyc == pend_due) begin
        imem_rvalid = 1'b1;
        imem_rdata  = (pend_epoch == epoch) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Model update and per-cycle compare, mid-cycle on stable signals.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_pc = 32'h0;
        pend   = 1'b0;
        epoch++;
      end else if (mon_en) begin
        // Decode consumes the IF/ID word.
        if (id_valid && !stall && !redirect) begin
          if (exp_q.size() == 0) begin
            chk("consume_unexpected", id_inst, 32'hxxxx_xxxx);
          end else begin
            chk("stream_inst", id_inst, exp_q[0].inst);
            chk("stream_pc4", id_pc_plus4, exp_q[0].pc4);
            chk("stream_imm", {16'h0, id_imm}, {16'h0, exp_q[0].inst[15:0]});
            void'(exp_q.pop_front());
          end
        end
        // Response returning to the fetch stage.
        if (imem_rvalid && pend) begin
          pend = 1'b0;
          if (pend_epoch == epoch && !redirect)
            exp_q.push_back('{inst: imem_rdata, pc4: pend_addr + 32'd4});
        end
        // Request accepted by memory.
        if (imem_req) begin
          chk("single_outstanding", {31'h0, pend}, 32'h0);
          if (imem_gnt) begin
            chk("fetch_addr", imem_addr, exp_pc);
            pend       = 1'b1;
            pend_addr  = imem_addr;
            pend_epoch = epoch;
            pend_due   = cyc + lat;
            exp_pc     = exp_pc + 32'd4;
          end
        end
        if (redirect) begin
          exp_q.delete();
          exp_pc = redirect_pc & ~32'h3;
          epoch++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int maxc);
    int k = 0;
    do begin tick(); k++; end while (!imem_req && k < maxc);
    n_chk++;
    if (!imem_req) begin
      n_fail++;
      $display("FAIL wait_req_timeout: req %b after %0d cycles, need 1", imem_req, k);
    end
  endtask

  task automatic wait_valid(input int maxc);
    int k = 0;
    do begin tick(); k++; end while (!id_valid && k < maxc);
    n_chk++;
    if (!id_valid) begin
      n_fail++;
      $display("FAIL wait_valid_timeout: id_valid %b after %0d cycles, need 1", id_valid, k);
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_inst",  id_inst, 32'h0);
    chk("rst_pc4",   id_pc_plus4, 32'h0);
    chk("rst_imm",   {16'h0, id_imm}, 32'h0);

    // Basic streaming.
    imem_gnt = 1'b1; rst = 1'b0; mon_en = 1'b1;
    tick(); chk("t1_req0", {31'h0, imem_req}, 32'h1); chk("t1_addr0", imem_addr, 32'h0);
    tick(); chk("t1_wait_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_valid", {31'h0, id_valid}, 32'h1);
    chk("t1_inst", id_inst, 32'h2008_0005);
    chk("t1_imm", {16'h0, id_imm}, 32'h0005);
    chk("t1_pc4", id_pc_plus4, 32'h4);
    tick();
    tick(); chk("t1_addr8", imem_addr, 32'h8); chk("t1_inst4", id_inst, 32'h2009_0005);

    // Stall for 3 cycles while the word for 0x8 returns.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_inst", id_inst, 32'h2009_0005);
      chk("t2_hold_valid", {31'h0, id_valid}, 32'h1);
      chk("t2_no_req", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("t2_skid_inst", id_inst, 32'h200A_0005);
    chk("t2_skid_pc4", id_pc_plus4, 32'hC);
    chk("t2_req_after", {31'h0, imem_req}, 32'h1);
    chk("t2_addr", imem_addr, 32'hC);

    // Redirect while waiting for a slow response.
    lat = 3;
    tick(); chk("t3_in_wait", {31'h0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    chk("t3_flush_valid", {31'h0, id_valid}, 32'h0);
    chk("t3_flush_inst", id_inst, 32'h0);
    chk("t3_drop_noreq", {31'h0, imem_req}, 32'h0);
    redirect = 1'b0; lat = 1;
    wait_req(10);
    chk("t3_addr40", imem_addr, 32'h40);
    chk("t3_no_beef", id_inst, 32'h0);
    wait_valid(10);
    chk("t3_inst", id_inst, 32'h2018_0005);
    chk("t3_pc4", id_pc_plus4, 32'h44);

    // Redirect together with stall while IF/ID is live; low bits ignored.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    chk("t4_valid", {31'h0, id_valid}, 32'h0);
    chk("t4_inst", id_inst, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    wait_req(10);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_valid(10);
    chk("t5_pc4_wrap", id_pc_plus4, 32'h0);
    chk("t5_inst", id_inst, 32'h2007_0005);
    chk("t5_next_addr", imem_addr, 32'h0);
    chk("t5_next_req", {31'h0, imem_req}, 32'h1);

    // Grant withheld, then redirect while the request is pending.
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_req_held", {31'h0, imem_req}, 32'h1);
      chk("t6_addr_held", imem_addr, 32'h0);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    chk("t6_req_still", {31'h0, imem_req}, 32'h1);
    chk("t6_addr_new", imem_addr, 32'h100);
    redirect = 1'b0; imem_gnt = 1'b1;
    wait_valid(10);
    chk("t6_inst", id_inst, 32'h2048_0005);
    chk("t6_pc4", id_pc_plus4, 32'h104);

    // Asynchronous reset in the middle of a transaction.
    tick();
    rst = 1'b1;
    #1;
    chk("t7_req", {31'h0, imem_req}, 32'h0);
    chk("t7_valid", {31'h0, id_valid}, 32'h0);
    chk("t7_inst", id_inst, 32'h0);
    chk("t7_pc4", id_pc_plus4, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t7_req_after", {31'h0, imem_req}, 32'h1);
    chk("t7_addr_after", imem_addr, 32'h0);
    wait_valid(10);
    chk("t7_inst_after", id_inst, 32'h2008_0005);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule : tb_if_fetch_stage
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.
- Holds the PC and issues one outstanding instruction-memory read at a time.
- Buffers the returned word and presents it to decode; id_imm (inst[15:0]) drives the immediate-extension unit directly.
- Supports decode stall (backpressure) and branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req  output  1  read request valid.
- imem_addr  output  32  read address, equal to the current PC.
- imem_gnt  input  1  address accepted this cycle; only meaningful when imem_req=1.
- imem_rvalid  input  1  read data valid; occurs at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- stall  input  1  decode cannot accept a new instruction this cycle.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  new PC; word aligned.
- id_valid  output  1  IF/ID holds a live instruction.
- id_inst  output  32  IF/ID instruction.
- id_pc_plus4  output  32  fetch PC + 4 for that instruction.
- id_imm  output  16  id_inst[15:0], feeds the immediate extender.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=IDLE, skid empty.
  - imem_req=0, id_valid=0, id_inst=32'h0 (NOP), id_pc_plus4=0, id_imm=0.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
  - IDLE: imem_req=0. Goes to REQ on the first clk edge after rst deasserts.
  - REQ: imem_req=1, imem_addr=pc.
    - gnt=1 -> WAIT.
    - Otherwise stay in REQ.
  - WAIT: imem_req=0. On rvalid:
    - If IF/ID can accept (stall=0 or id_valid=0): id_inst<=rdata, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4, -> REQ.
    - Else: capture rdata into the skid, pc<=pc+4, -> HOLD.
  - HOLD: imem_req=0. When stall=0, the skid moves into IF/ID (id_valid=1), skid empties, -> REQ.
  - DROP: imem_req=0. Waits for the rvalid belonging to a cancelled request, discards it (IF/ID untouched), -> REQ.
- IF/ID with no new data:
  - stall=0 and no load this cycle -> id_valid<=0 (bubble).
  - stall=1 -> all IF/ID fields hold.
- Redirect (priority over stall and over any load):
  - pc<=redirect_pc, id_valid<=0, id_inst<=0, skid cleared.
  - Next state depends on the current state:
    - REQ with gnt=1 -> DROP.
    - REQ with gnt=0 -> stay REQ; imem_addr shows the new pc next cycle. This is the only case where the address changes while a request is pending.
    - WAIT with rvalid=0 -> DROP.
    - WAIT with rvalid=1 -> data discarded, -> REQ.
    - HOLD -> REQ.
    - DROP -> stays DROP; a response arriving the same cycle is discarded and the state goes to REQ.
    - IDLE -> pc updated, normal IDLE exit.
- Throughput:
  - Best case is one instruction per 2 cycles (REQ+gnt, then rvalid next cycle).
  - The single-outstanding rule keeps the skid at 1 entry.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). pc[1:0] is always 0; redirect_pc[1:0] is ignored (forced to 0).
- id_imm is purely combinational from the id_inst register, so it has zero added latency.
- Reset asserted mid-transaction: everything is cleared immediately. Responses still in flight after reset are not this block's responsibility; the memory is reset together with this block.

Decomposition:
- mips_pkg holds:
  - NOP_INST = 32'h0000_0000
  - DEFAULT_RESET_PC
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, DROP}
- One natural sub-module: if_skid_reg, a 1-entry data+valid holding register with load/clear/pop.

Test Plan:
- Reset release, RESET_PC=0, gnt tied 1, rvalid one cycle after gnt, rdata=0x2008_0005, stall=0:
  - imem_addr=0x0 on the cycle after reset, then 0x4, 0x8.
  - id_inst=0x2008_0005, id_imm=0x0005, id_pc_plus4=0x4.
- Stall held 3 cycles while a response arrives:
  - IF/ID holds its value; the response goes to the skid; no new imem_req.
  - On the release cycle, id_inst updates to the skid word and REQ follows; no instruction is lost or duplicated.
- Redirect to 0x0000_0040 while in WAIT:
  - id_valid=0 next cycle; FSM in DROP.
  - The late rvalid (rdata=0xDEAD_BEEF) never appears on id_inst.
  - Next imem_addr=0x40.
- Redirect and stall asserted together with id_valid=1:
  - Flush wins: id_valid=0, id_inst=0, pc=redirect_pc.
- PC wrap, redirect_pc=0xFFFF_FFFC:
  - Fetched instruction has id_pc_plus4=0x0000_0000.
  - Next imem_addr=0x0.
- gnt held 0 for 5 cycles in REQ, then redirect to 0x100:
  - imem_req stays 1; imem_addr changes to 0x100 the following cycle.
  - No DROP state is entered.
